// File: rtl/decode_hazard_controller.sv
// Decode-stage sequencer: owns the IF/ID and ID/EX instruction registers, detects
// load-use hazards, flushes on EX redirects and freezes the front end on memory stalls.
module decode_hazard_controller #(
    parameter int CNT_W            = 16,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instruction,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_ready,
    output logic             id_valid,
    output logic [31:0]      id_instruction,
    output logic             ex_valid,
    output logic [31:0]      ex_instruction,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, REDIRECT} state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [2:0] BUBBLE_INIT = 3'(REDIRECT_BUBBLES);

    state_t     state;
    logic [2:0] bubble_count;

    logic [6:0] id_opcode;
    logic [6:0] ex_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       load_use;

    assign id_opcode = id_instruction[6:0];
    assign id_rs1    = id_instruction[19:15];
    assign id_rs2    = id_instruction[24:20];
    assign ex_opcode = ex_instruction[6:0];
    assign ex_rd     = ex_instruction[11:7];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OP_OP, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    // A load into x0 never produces a value, so it can never be the source of a hazard.
    assign load_use = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) && id_valid &&
                      ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd))) &&
                      (state != REDIRECT);

    always_comb begin
        pc_en        = 1'b0;
        if_ready     = 1'b0;
        hazard_stall = 1'b0;
        if (!mem_busy) begin
            if (ex_redirect) begin
                pc_en = 1'b1;
            end else if (state == REDIRECT) begin
                pc_en    = 1'b1;
                if_ready = 1'b1;
            end else if (load_use) begin
                hazard_stall = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            bubble_count   <= 3'd0;
            id_valid       <= 1'b0;
            id_instruction <= 32'd0;
            ex_valid       <= 1'b0;
            ex_instruction <= 32'd0;
            stall_count    <= '0;
            flush_count    <= '0;
        end else if (!mem_busy) begin
            if (ex_redirect) begin
                id_valid     <= 1'b0;
                ex_valid     <= 1'b0;
                state        <= REDIRECT;
                bubble_count <= BUBBLE_INIT;
                if (flush_count != '1)
                    flush_count <= flush_count + CNT_W'(1);
            end else if (state == REDIRECT) begin
                // Words fetched from the wrong path are latched but marked invalid.
                if (if_valid)
                    id_instruction <= if_instruction;
                id_valid     <= 1'b0;
                ex_valid     <= 1'b0;
                bubble_count <= bubble_count - 3'd1;
                if (bubble_count <= 3'd1)
                    state <= RUN;
            end else if (load_use) begin
                ex_valid       <= 1'b0;
                ex_instruction <= 32'd0;
                state          <= LOAD_STALL;
                if (stall_count != '1)
                    stall_count <= stall_count + CNT_W'(1);
            end else begin
                ex_valid       <= id_valid;
                ex_instruction <= id_instruction;
                id_valid       <= if_valid;
                if (if_valid)
                    id_instruction <= if_instruction;
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Directed scoreboard bench for decode_hazard_controller (CNT_W=4, REDIRECT_BUBBLES=2).
module tb_decode_hazard_controller;

    localparam logic [31:0] LW1  = 32'h00012083;
    localparam logic [31:0] ADD  = 32'h004081B3;
    localparam logic [31:0] LW0  = 32'h00012003;
    localparam logic [31:0] ADD0 = 32'h00000033;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] W1   = 32'h00100093;
    localparam logic [31:0] W2   = 32'h00200113;
    localparam logic [31:0] W3   = 32'h00300193;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic        ex_redirect;
    logic        mem_busy;
    logic        pc_en;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic        ex_valid;
    logic [31:0] ex_instruction;
    logic        hazard_stall;
    logic [3:0]  stall_count;
    logic [3:0]  flush_count;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        logic        pc_en;
        logic        if_ready;
        logic        hazard_stall;
        logic        id_valid;
        logic [31:0] id_instruction;
        logic        ex_valid;
        logic [31:0] ex_instruction;
        logic [3:0]  stall_count;
        logic [3:0]  flush_count;
    } exp_t;

    exp_t sb[$];

    decode_hazard_controller #(.CNT_W(4), .REDIRECT_BUBBLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .ex_redirect    (ex_redirect),
        .mem_busy       (mem_busy),
        .pc_en          (pc_en),
        .if_ready       (if_ready),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .ex_valid       (ex_valid),
        .ex_instruction (ex_instruction),
        .hazard_stall   (hazard_stall),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "pc_en",          32'(pc_en),          32'(e.pc_en));
        chk(e.tag, "if_ready",       32'(if_ready),       32'(e.if_ready));
        chk(e.tag, "hazard_stall",   32'(hazard_stall),   32'(e.hazard_stall));
        chk(e.tag, "id_valid",       32'(id_valid),       32'(e.id_valid));
        chk(e.tag, "id_instruction", id_instruction,      e.id_instruction);
        chk(e.tag, "ex_valid",       32'(ex_valid),       32'(e.ex_valid));
        chk(e.tag, "ex_instruction", ex_instruction,      e.ex_instruction);
        chk(e.tag, "stall_count",    32'(stall_count),    32'(e.stall_count));
        chk(e.tag, "flush_count",    32'(flush_count),    32'(e.flush_count));
    endtask

    // Drive one cycle of inputs, queue the expected outputs for that cycle, then compare.
    task automatic applyStimulus(input string tag, input logic rst, input logic ifv,
                                 input logic [31:0] instr, input logic redir, input logic busy,
                                 input logic pc, input logic ir, input logic hs,
                                 input logic idv, input logic [31:0] idi,
                                 input logic exv, input logic [31:0] exi,
                                 input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        @(negedge clk);
        rst_n          = rst;
        if_valid       = ifv;
        if_instruction = instr;
        ex_redirect    = redir;
        mem_busy       = busy;
        e.tag = tag; e.pc_en = pc; e.if_ready = ir; e.hazard_stall = hs;
        e.id_valid = idv; e.id_instruction = idi; e.ex_valid = exv; e.ex_instruction = exi;
        e.stall_count = sc; e.flush_count = fc;
        sb.push_back(e);
        #1;
        checkOutput();
    endtask

    function automatic logic [3:0] sat(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    initial begin
        rst_n = 1'b0; if_valid = 1'b1; if_instruction = LW1; ex_redirect = 1'b0; mem_busy = 1'b0;

        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("reset%0d", i), 0, 1, LW1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("release",      1, 1, LW1,  0, 0, 1, 1, 0, 0, 0,    0, 0,    0, 0);

        applyStimulus("lu_fetch_add", 1, 1, ADD,  0, 0, 1, 1, 0, 1, LW1,  0, 0,    0, 0);
        applyStimulus("lu_stall",     1, 1, NOP,  0, 0, 0, 0, 1, 1, ADD,  1, LW1,  0, 0);
        applyStimulus("lu_resume",    1, 1, NOP,  0, 0, 1, 1, 0, 1, ADD,  0, 0,    1, 0);
        applyStimulus("lu_add_in_ex", 1, 0, NOP,  0, 0, 1, 1, 0, 1, NOP,  1, ADD,  1, 0);

        applyStimulus("x0_fetch_lw",  1, 1, LW0,  0, 0, 1, 1, 0, 0, NOP,  1, NOP,  1, 0);
        applyStimulus("x0_fetch_add", 1, 1, ADD0, 0, 0, 1, 1, 0, 1, LW0,  0, NOP,  1, 0);
        applyStimulus("x0_no_stall",  1, 1, NOP,  0, 0, 1, 1, 0, 1, ADD0, 1, LW0,  1, 0);

        applyStimulus("rd_fetch_lw",  1, 1, LW1,  0, 0, 1, 1, 0, 1, NOP,  1, ADD0, 1, 0);
        applyStimulus("rd_fetch_add", 1, 1, ADD,  0, 0, 1, 1, 0, 1, LW1,  1, NOP,  1, 0);
        applyStimulus("rd_pulse",     1, 1, W1,   1, 0, 1, 0, 0, 1, ADD,  1, LW1,  1, 0);
        applyStimulus("rd_bubble1",   1, 1, W1,   0, 0, 1, 1, 0, 0, ADD,  0, LW1,  1, 1);
        applyStimulus("rd_bubble2",   1, 1, W2,   0, 0, 1, 1, 0, 0, W1,   0, LW1,  1, 1);
        applyStimulus("rd_third",     1, 1, W3,   0, 0, 1, 1, 0, 0, W2,   0, LW1,  1, 1);
        applyStimulus("rd_third_id",  1, 0, NOP,  0, 0, 1, 1, 0, 1, W3,   0, W2,   1, 1);
        applyStimulus("rd_third_ex",  1, 0, NOP,  0, 0, 1, 1, 0, 0, W3,   1, W3,   1, 1);

        applyStimulus("mb_fetch_lw",  1, 1, LW1,  0, 0, 1, 1, 0, 0, W3,   0, W3,   1, 1);
        applyStimulus("mb_fetch_add", 1, 1, ADD,  0, 0, 1, 1, 0, 1, LW1,  0, W3,   1, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("mb_busy%0d", i), 1, 1, NOP, 1, 1, 0, 0, 0, 1, ADD, 1, LW1, 1, 1);
        applyStimulus("mb_release",   1, 1, NOP,  1, 0, 1, 0, 0, 1, ADD,  1, LW1,  1, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("mb_after%0d", i), 1, 0, NOP, 0, 0, 1, 1, 0, 0, ADD, 0, LW1, 1, 2);

        applyStimulus("sat_pre",      1, 1, LW1,  0, 0, 1, 1, 0, 0, ADD,  0, ADD,  1, 2);
        for (int k = 0; k < 20; k++) begin
            applyStimulus($sformatf("sat%0d_add", k),   1, 1, ADD, 0, 0, 1, 1, 0,
                          1, LW1, (k == 0) ? 1'b0 : 1'b1, ADD, sat(1 + k), 2);
            applyStimulus($sformatf("sat%0d_stall", k), 1, 1, LW1, 0, 0, 0, 0, 1,
                          1, ADD, 1, LW1, sat(1 + k), 2);
            applyStimulus($sformatf("sat%0d_next", k),  1, 1, LW1, 0, 0, 1, 1, 0,
                          1, ADD, 0, 0, sat(2 + k), 2);
        end
        applyStimulus("post_add",     1, 1, ADD,  0, 0, 1, 1, 0, 1, LW1,  1, ADD,  15, 2);
        applyStimulus("post_stall",   1, 1, LW1,  0, 0, 0, 0, 1, 1, ADD,  1, LW1,  15, 2);
        applyStimulus("reset_mid",    0, 1, LW1,  0, 0, 1, 1, 0, 0, 0,    0, 0,    0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
